pci_rr_arbiter: RTL and testbench

- Central PCI bus arbiter for four masters; samples active-low REQ# lines and bus-idle state, picks one master by round-robin.
- Produces a 2-bit grant index plus grant enable.
- Both outputs feed the active-low 2-to-4 GNT# decoder directly downstream, which turns them into the GNT# lines.
- Also tracks transaction ownership and revokes grants a master never uses.

---
 rtl/pci_rr_arbiter_if.sv | 28 ++
 rtl/pci_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pci_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pci_rr_arbiter_if.sv
// PCI arbitration signal bundle: REQ#/FRAME#/IRDY# in, grant index/enable and busy out.
// The arbiter uses the master modport; the bus-side model uses slave.
interface pci_rr_arbiter_if;
    logic [3:0] REQ_N;
    logic       FRAME_N;
    logic       IRDY_N;
    logic [1:0] GNT_IDX;
    logic       GNT_EN;
    logic       BUS_BUSY;

    modport master (
        input  REQ_N,
        input  FRAME_N,
        input  IRDY_N,
        output GNT_IDX,
        output GNT_EN,
        output BUS_BUSY
    );

    modport slave (
        output REQ_N,
        output FRAME_N,
        output IRDY_N,
        input  GNT_IDX,
        input  GNT_EN,
        input  BUS_BUSY
    );
endinterface

// File: rtl/pci_rr_arbiter.sv
// Four-master round-robin PCI arbiter with unused-grant timeout; grant visible 1 clock after request.
// Optional bus parking on PARK_IDX when idle is enabled by defining BUS_PARKING_EN.
module pci_rr_arbiter #(
    parameter int         TIMEOUT  = 16,
    parameter logic [1:0] PARK_IDX = 2'd0
) (
    input  logic                  CLK,
    input  logic                  RST,
    pci_rr_arbiter_if.master      io_bus
);

`ifdef BUS_PARKING_EN
    localparam bit P_PARK_EN = 1'b1;
`else
    localparam bit P_PARK_EN = 1'b0;
`endif

    localparam logic [7:0] P_TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_PARK  = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_en;
    logic       r_bus_busy;
    logic [1:0] r_last_owner;
    logic [7:0] r_timer;

    state_t     w_state_nxt;
    logic [1:0] w_gnt_idx_nxt;
    logic       w_gnt_en_nxt;
    logic       w_bus_busy_nxt;
    logic [1:0] w_last_owner_nxt;
    logic [7:0] w_timer_nxt;

    logic       w_bus_idle;
    logic       w_any_req;
    logic [1:0] w_winner;
    logic [1:0] w_cand;
    logic       w_owner_req;

    assign w_bus_idle  = io_bus.FRAME_N & io_bus.IRDY_N;
    assign w_owner_req = ~io_bus.REQ_N[r_gnt_idx];

    // Search starts just after the previous owner so every requester is reached within four grants.
    always_comb begin
        w_winner  = r_last_owner;
        w_any_req = 1'b0;
        w_cand    = r_last_owner;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last_owner + 2'(k);
            if (!w_any_req && !io_bus.REQ_N[w_cand]) begin
                w_winner  = w_cand;
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_idx_nxt    = r_gnt_idx;
        w_gnt_en_nxt     = r_gnt_en;
        w_bus_busy_nxt   = r_bus_busy;
        w_last_owner_nxt = r_last_owner;
        w_timer_nxt      = r_timer;

        case (r_state)
            ST_IDLE: begin
                w_gnt_en_nxt = 1'b0;
                if (w_any_req && w_bus_idle) begin
                    w_gnt_idx_nxt = w_winner;
                    w_gnt_en_nxt  = 1'b1;
                    w_timer_nxt   = P_TMO;
                    w_state_nxt   = ST_GRANT;
                end else if (P_PARK_EN && !w_any_req && w_bus_idle) begin
                    w_gnt_idx_nxt = PARK_IDX;
                    w_gnt_en_nxt  = 1'b1;
                    w_state_nxt   = ST_PARK;
                end
            end

            ST_PARK: begin
                if (!io_bus.FRAME_N) begin
                    w_bus_busy_nxt = 1'b1;
                    w_state_nxt    = ST_BUSY;
                end else if (w_any_req) begin
                    if (w_winner == PARK_IDX) begin
                        w_timer_nxt = P_TMO;
                        w_state_nxt = ST_GRANT;
                    end else begin
                        // Drop park first so the new grant still gets its turnaround clock.
                        w_gnt_en_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end

            ST_GRANT: begin
                if (!io_bus.FRAME_N) begin
                    w_bus_busy_nxt = 1'b1;
                    w_state_nxt    = ST_BUSY;
                end else if (!w_owner_req) begin
                    w_gnt_en_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                    if (r_timer <= 8'd1) begin
                        w_gnt_en_nxt     = 1'b0;
                        w_last_owner_nxt = r_gnt_idx;
                        w_state_nxt      = ST_IDLE;
                    end
                end
            end

            ST_BUSY: begin
                if (w_bus_idle) begin
                    w_bus_busy_nxt   = 1'b0;
                    w_gnt_en_nxt     = 1'b0;
                    w_last_owner_nxt = r_gnt_idx;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_gnt_en_nxt = r_gnt_en & w_owner_req;
                end
            end

            default: begin
                w_gnt_en_nxt   = 1'b0;
                w_bus_busy_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_gnt_idx    <= 2'd0;
            r_gnt_en     <= 1'b0;
            r_bus_busy   <= 1'b0;
            r_last_owner <= 2'd3;
            r_timer      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_idx    <= w_gnt_idx_nxt;
            r_gnt_en     <= w_gnt_en_nxt;
            r_bus_busy   <= w_bus_busy_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    assign io_bus.GNT_IDX  = r_gnt_idx;
    assign io_bus.GNT_EN   = r_gnt_en;
    assign io_bus.BUS_BUSY = r_bus_busy;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter: vector table plus hand sequences for timeout, withdrawal and reset.
module tb_pci_rr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pci_rr_arbiter_if bus();

    pci_rr_arbiter #(.TIMEOUT(16), .PARK_IDX(2'd0)) dut (
        .CLK    (clk),
        .RST    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req_n;
        logic       frame_n;
        logic       irdy_n;
        logic       en;
        logic [1:0] idx;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input logic r, input logic [3:0] rq,
                                input logic f, input logic ir, input logic e,
                                input logic [1:0] ix, input logic b);
        vec_t v;
        v.name = nm; v.rst = r; v.req_n = rq; v.frame_n = f; v.irdy_n = ir;
        v.en = e; v.idx = ix; v.busy = b;
        tbl.push_back(v);
    endfunction

    task automatic step_chk(input string nm, input logic r, input logic [3:0] rq,
                            input logic f, input logic ir, input logic e,
                            input logic [1:0] ix, input logic b);
        rst         = r;
        bus.REQ_N   = rq;
        bus.FRAME_N = f;
        bus.IRDY_N  = ir;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.GNT_EN !== e || bus.GNT_IDX !== ix || bus.BUS_BUSY !== b) begin
            n_fail++;
            $display("FAIL %s: got en=%b idx=%0d busy=%b, want en=%b idx=%0d busy=%b",
                     nm, bus.GNT_EN, bus.GNT_IDX, bus.BUS_BUSY, e, ix, b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset, then quiet idle.
        add("reset0", 1, 4'b1111, 1, 1, 0, 2'd0, 0);
        add("reset1", 1, 4'b1111, 1, 1, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) add("post_reset_idle", 0, 4'b1111, 1, 1, 0, 2'd0, 0);

        // Fairness: all request, each master runs a 2-cycle FRAME# pulse.
        for (int m = 0; m < 4; m++) begin
            add("fair_grant", 0, 4'b0000, 1, 1, 1, 2'(m), 0);
            add("fair_busy0", 0, 4'b0000, 0, 1, 1, 2'(m), 1);
            add("fair_busy1", 0, 4'b0000, 0, 1, 1, 2'(m), 1);
            add("fair_gap",   0, 4'b0000, 1, 1, 0, 2'(m), 0);
        end
        add("fair_wrap",  0, 4'b0000, 1, 1, 1, 2'd0, 0);
        add("fair_wbusy", 0, 4'b0000, 0, 1, 1, 2'd0, 1);
        add("fair_wend",  0, 4'b0000, 1, 1, 0, 2'd0, 0);

        // Single master 1, including IRDY# tail and owner dropping REQ# mid-transaction.
        add("single_grant", 0, 4'b1101, 1, 1, 1, 2'd1, 0);
        for (int i = 0; i < 3; i++) add("single_busy", 0, 4'b1101, 0, 1, 1, 2'd1, 1);
        add("single_irdy_tail", 0, 4'b1101, 1, 0, 1, 2'd1, 1);
        add("single_req_drop",  0, 4'b1111, 0, 0, 0, 2'd1, 1);
        add("single_end",       0, 4'b1111, 1, 1, 0, 2'd1, 0);
        add("single_idle",      0, 4'b1111, 1, 1, 0, 2'd1, 0);

        // FRAME# beats a same-cycle withdrawal.
        add("prec_grant",    0, 4'b1101, 1, 1, 1, 2'd1, 0);
        add("prec_frame",    0, 4'b1111, 0, 1, 1, 2'd1, 1);
        add("prec_en_drop",  0, 4'b1111, 0, 1, 0, 2'd1, 1);
        add("prec_end",      0, 4'b1111, 1, 1, 0, 2'd1, 0);

        foreach (tbl[i])
            step_chk(tbl[i].name, tbl[i].rst, tbl[i].req_n, tbl[i].frame_n, tbl[i].irdy_n,
                     tbl[i].en, tbl[i].idx, tbl[i].busy);

        // Timeout: master 2 never drives FRAME#, grant lasts exactly 16 clocks.
        for (int i = 0; i < 16; i++) step_chk("timeout_hold", 0, 4'b0011, 1, 1, 1, 2'd2, 0);
        step_chk("timeout_gap",  0, 4'b0011, 1, 1, 0, 2'd2, 0);
        step_chk("timeout_next", 0, 4'b0011, 1, 1, 1, 2'd3, 0);
        step_chk("timeout_wdraw", 0, 4'b1111, 1, 1, 0, 2'd3, 0);

        // Withdrawal before FRAME#.
        step_chk("wd_grant",   0, 4'b1110, 1, 1, 1, 2'd0, 0);
        step_chk("wd_drop",    0, 4'b1111, 1, 1, 0, 2'd0, 0);
        step_chk("wd_idle",    0, 4'b1111, 1, 1, 0, 2'd0, 0);
        step_chk("wd_regrant", 0, 4'b1110, 1, 1, 1, 2'd0, 0);
        step_chk("wd_drop2",   0, 4'b1111, 1, 1, 0, 2'd0, 0);

        // Reset in the middle of master 2's transaction.
        step_chk("rmid_grant", 0, 4'b1011, 1, 1, 1, 2'd2, 0);
        step_chk("rmid_busy",  0, 4'b1011, 0, 1, 1, 2'd2, 1);
        step_chk("rmid_rst",   1, 4'b0000, 0, 1, 0, 2'd0, 0);
        step_chk("rmid_first", 0, 4'b0000, 1, 1, 1, 2'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
